// File: rtl/fifo_ptr_pkg.sv
// fifo_ptr_pkg
//   Shared definitions for the async-FIFO Gray pointer controllers:
//   side selectors, Gray/binary conversion helpers and the pointer
//   width helper (pointer carries one wrap bit above the address).
package fifo_ptr_pkg;

  localparam int MODE_WR = 0;   // write side, flag = full
  localparam int MODE_RD = 1;   // read side,  flag = empty

  // Extra pointer bit above the address: distinguishes full from empty.
  localparam int PTR_WRAP_BITS = 1;

  // Widest pointer the conversion helpers handle.
  localparam int GRAY_MAX_W = 32;

  function automatic int ptr_width(input int ptr);
    return ptr + PTR_WRAP_BITS;
  endfunction

  // Helpers take zero-extended operands up to GRAY_MAX_W bits; the zero
  // upper bits leave the low-order result identical for any narrower width.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--)
      bin[i] = bin[i+1] ^ gray[i];
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray_ptr_ctrl_sync.sv
// gray_sync_chain
//   Multi-flop synchroniser bringing the remote domain's Gray pointer into
//   the local clock. Only one bit changes per remote step, so any stage
//   resolves to either the old or the new pointer.
//   Ports: clk, rst (sync, active high), d (async Gray in), q (last stage).
module gray_sync_chain #(
  parameter int W      = 5,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] stg;

  always_ff @(posedge clk) begin
    if (rst) stg <= '0;
    else     stg <= {stg[STAGES-2:0], d};
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/fifo_gray_ptr_ctrl.sv
// fifo_gray_ptr_ctrl
//   Registered Gray-code pointer controller for one side of an async FIFO.
//   MODE selects write side (flag = full) or read side (flag = empty).
//   Optional occupancy output enabled by macro FIFO_PTR_LEVEL_EN.
//   Ports:
//     clk, rst      local clock, synchronous active-high reset
//     inc           push (write side) / pop (read side) request
//     remote_gray   other domain's Gray pointer (asynchronous)
//     addr          RAM address (low PTR bits of ptr_bin)
//     ptr_bin       registered binary pointer (PTR+1 bits)
//     ptr_gray      registered Gray pointer, sent to the other domain
//     flag          registered full (MODE 0) / empty (MODE 1)
//     level         occupancy, only with FIFO_PTR_LEVEL_EN
module fifo_gray_ptr_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int PTR         = 4,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic [PTR:0] remote_gray,
  output logic [PTR-1:0] addr,
  output logic [PTR:0] ptr_bin,
  output logic [PTR:0] ptr_gray,
  output logic         flag
`ifdef FIFO_PTR_LEVEL_EN
  ,
  output logic [PTR:0] level
`endif
);

  localparam int PW = ptr_width(PTR);

  logic          inc_q;
  logic [PW-1:0] bin_next, gray_next, remote_sync;
  logic          flag_next;

  gray_sync_chain #(.W(PW), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (remote_gray),
    .q   (remote_sync)
  );

  // A request while full/empty is dropped; pointer holds.
  assign inc_q     = inc & ~flag;
  assign bin_next  = ptr_bin + PW'(inc_q);
  assign gray_next = PW'(bin2gray(GRAY_MAX_W'(bin_next)));

  // Flag is judged against the pointer about to be registered, so it rises
  // on the very edge that fills/empties the FIFO.
  generate
    if (MODE == MODE_WR) begin : g_full
      // Full: remote is exactly one lap behind -> top two Gray bits inverted.
      assign flag_next = (gray_next == {~remote_sync[PW-1:PW-2], remote_sync[PW-3:0]});
    end else begin : g_empty
      assign flag_next = (gray_next == remote_sync);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_bin  <= '0;
      ptr_gray <= '0;
      flag     <= (MODE == MODE_RD);
    end else begin
      ptr_bin  <= bin_next;
      ptr_gray <= gray_next;
      flag     <= flag_next;
    end
  end

  assign addr = ptr_bin[PTR-1:0];

`ifdef FIFO_PTR_LEVEL_EN
  logic [PW-1:0] remote_bin, level_next;

  assign remote_bin = PW'(gray2bin(GRAY_MAX_W'(remote_sync)));

  generate
    if (MODE == MODE_WR) begin : g_lvl_wr
      assign level_next = bin_next - remote_bin;
    end else begin : g_lvl_rd
      assign level_next = remote_bin - bin_next;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) level <= '0;
    else     level <= level_next;
  end
`endif

endmodule

// File: tb/tb_fifo_gray_ptr_ctrl.sv
// tb_fifo_gray_ptr_ctrl
//   Directed bench for fifo_gray_ptr_ctrl with PTR=2, SYNC_STAGES=2.
//   One write-side and one read-side instance share clock and reset.
//   Optional level checks with FIFO_PTR_LEVEL_EN.
module tb_fifo_gray_ptr_ctrl;

  localparam int PTR = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           inc_w, inc_r;
  logic [PTR:0]   rg_w, rg_r;
  logic [PTR-1:0] addr_w, addr_r;
  logic [PTR:0]   bin_w, bin_r, gray_w, gray_r;
  logic           flag_w, flag_r;
`ifdef FIFO_PTR_LEVEL_EN
  logic [PTR:0]   lvl_w, lvl_r;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_gray_ptr_ctrl #(.PTR(PTR), .MODE(0), .SYNC_STAGES(2)) u_wr (
    .clk(clk), .rst(rst), .inc(inc_w), .remote_gray(rg_w),
    .addr(addr_w), .ptr_bin(bin_w), .ptr_gray(gray_w), .flag(flag_w)
`ifdef FIFO_PTR_LEVEL_EN
    , .level(lvl_w)
`endif
  );

  fifo_gray_ptr_ctrl #(.PTR(PTR), .MODE(1), .SYNC_STAGES(2)) u_rd (
    .clk(clk), .rst(rst), .inc(inc_r), .remote_gray(rg_r),
    .addr(addr_r), .ptr_bin(bin_r), .ptr_gray(gray_r), .flag(flag_r)
`ifdef FIFO_PTR_LEVEL_EN
    , .level(lvl_r)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PTR:0] g(input logic [PTR:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    logic [PTR:0] prev_bin, prev_gray, exp_bin;
    logic         prev_flag;
    int           nacc, wraps, cyc;

    rst = 1'b1; inc_w = 1'b0; inc_r = 1'b0; rg_w = '0; rg_r = '0;
    step();
    chk("rst_bin_w",  bin_w,  0);
    chk("rst_gray_w", gray_w, 0);
    chk("rst_addr_w", addr_w, 0);
    chk("rst_flag_w", flag_w, 0);
    chk("rst_flag_r", flag_r, 1);
    chk("rst_bin_r",  bin_r,  0);

    // 1. Fill
    rst = 1'b0; inc_w = 1'b1;
    step(); chk("fill1_bin", bin_w, 1); chk("fill1_gray", gray_w, 3'b001); chk("fill1_flag", flag_w, 0);
    step(); chk("fill2_bin", bin_w, 2); chk("fill2_gray", gray_w, 3'b011); chk("fill2_flag", flag_w, 0);
    step(); chk("fill3_bin", bin_w, 3); chk("fill3_gray", gray_w, 3'b010); chk("fill3_flag", flag_w, 0);
    chk("fill3_addr", addr_w, 3);
    step(); chk("fill4_bin", bin_w, 4); chk("fill4_gray", gray_w, 3'b110); chk("fill4_flag", flag_w, 1);
    chk("fill4_addr", addr_w, 0);
    step(); chk("fill5_bin_hold", bin_w, 4); chk("fill5_flag", flag_w, 1);

    // 2. Drain release
    inc_w = 1'b0; rg_w = 3'b001;
    step(); chk("drain_e1_flag", flag_w, 1);
    step(); chk("drain_e2_flag", flag_w, 1);
    step(); chk("drain_e3_flag", flag_w, 0);
    inc_w = 1'b1;
    step(); chk("drain_push_gray", gray_w, 3'b111); chk("drain_push_flag", flag_w, 1);
    inc_w = 1'b0;

    // 3. Empty side
    rst = 1'b1; step(); rst = 1'b0;
    inc_r = 1'b1;
    step(); chk("empty_ign_bin", bin_r, 0); chk("empty_ign_flag", flag_r, 1);
    inc_r = 1'b0; rg_r = 3'b001;
    step(); chk("empty_e1_flag", flag_r, 1);
    step(); chk("empty_e2_flag", flag_r, 1);
    step(); chk("empty_e3_flag", flag_r, 0);
    inc_r = 1'b1;
    step(); chk("empty_pop_bin", bin_r, 1); chk("empty_pop_flag", flag_r, 1);
    inc_r = 1'b0;

    // 4. Wrap: remote tracks local write pointer with lag 2
    rst = 1'b1; rg_w = '0; step(); rst = 1'b0;
    nacc = 0; wraps = 0; cyc = 0;
    inc_w = 1'b1;
    prev_bin = bin_w; prev_gray = gray_w; prev_flag = flag_w;
    rg_w = g(bin_w - 3'd2);
    while (nacc < 16 && cyc < 100) begin
      step(); cyc++;
      exp_bin = prev_flag ? prev_bin : prev_bin + 3'd1;
      chk("wrap_bin", bin_w, exp_bin);
      chk("wrap_gray_code", gray_w, g(exp_bin));
      if (!prev_flag) begin
        nacc++;
        chk("wrap_hamming", $countones(gray_w ^ prev_gray), 1);
        if (bin_w == 0) wraps++;
      end
      prev_bin = bin_w; prev_gray = gray_w; prev_flag = flag_w;
      rg_w = g(bin_w - 3'd2);
    end
    chk("wrap_accepted", nacc, 16);
    chk("wrap_zero_returns", wraps, 2);
    inc_w = 1'b0;

    // 5. Reset mid-operation
    rst = 1'b1; rg_w = '0; step(); rst = 1'b0;
    inc_w = 1'b1;
    step(); step(); step();
    chk("mid_pre_bin", bin_w, 3);
    inc_w = 1'b0; rg_w = 3'b011;
    step(); step();
    chk("mid_pre_sync", u_wr.remote_sync, 3'b011);
    rst = 1'b1; inc_w = 1'b1; inc_r = 1'b1;
    step();
    chk("mid_rst_bin",  bin_w, 0);
    chk("mid_rst_gray", gray_w, 0);
    chk("mid_rst_flag_w", flag_w, 0);
    chk("mid_rst_flag_r", flag_r, 1);
    chk("mid_rst_sync", u_wr.remote_sync, 0);
    rst = 1'b0; inc_w = 1'b0; inc_r = 1'b0; rg_w = '0; rg_r = '0;

`ifdef FIFO_PTR_LEVEL_EN
    // 6. Level
    rst = 1'b1; step(); rst = 1'b0;
    chk("lvl_rst", lvl_w, 0);
    inc_w = 1'b1;
    step(); chk("lvl_1", lvl_w, 1);
    step(); chk("lvl_2", lvl_w, 2);
    step(); chk("lvl_3", lvl_w, 3);
    inc_w = 1'b0; rg_w = 3'b001;
    step(); chk("lvl_hold1", lvl_w, 3);
    step(); chk("lvl_hold2", lvl_w, 3);
    step(); chk("lvl_after_sync", lvl_w, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_gray_ptr_ctrl.md
Name: fifo_gray_ptr_ctrl

Overview:
Parametrised, registered Gray-code pointer controller for one side of the async FIFO.
- Holds the local binary and Gray pointer, which is one bit wider than the address.
- Advances the pointer on a qualified increment.
- Synchronises the remote domain's Gray pointer into the local clock.
- Produces a registered full flag (write side) or empty flag (read side), chosen by MODE.
- One instance per clock domain; two instances plus the RAM form the async FIFO.

Parameters:
PTR, 4, address width; FIFO depth = 2**PTR; pointer width = PTR+1; legal PTR >= 2
MODE, 0, 0 = write side (flag = full), 1 = read side (flag = empty)
SYNC_STAGES, 2, flops in remote-pointer synchroniser; legal >= 2

Ports:
clk  input  1  local domain clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
inc  input  1  push (MODE 0) or pop (MODE 1) request
remote_gray  input  PTR+1  Gray pointer from the other clock domain (asynchronous to clk)
addr  output  PTR  RAM address = ptr_bin[PTR-1:0]
ptr_bin  output  PTR+1  registered local binary pointer
ptr_gray  output  PTR+1  registered local Gray pointer, sent to the other domain
flag  output  1  registered full (MODE 0) or empty (MODE 1)
level  output  PTR+1  occupancy; present only with FIFO_PTR_LEVEL_EN

Behaviour:
- Reset, on the clk edge with rst=1, regardless of inc:
  - ptr_bin=0, ptr_gray=0, addr=0, all sync stages=0, level=0.
  - flag=0 in MODE 0; flag=1 in MODE 1.
- Qualified increment: inc_q = inc & ~flag. An inc while flag=1 is ignored; the pointer holds.
- Next pointer:
  - bin_next = ptr_bin + inc_q, modulo 2**(PTR+1).
  - gray_next = bin_next ^ (bin_next >> 1).
  - Both are registered on the same edge. Latency from inc to pointer change is 1 cycle.
- Gray output:
  - ptr_gray comes directly from a flop; there is no combinational path from inc to ptr_gray.
  - Consecutive ptr_gray values differ in exactly one bit, including the wrap from 2**(PTR+1)-1 back to 0.
- Synchroniser:
  - remote_gray passes through SYNC_STAGES flops; remote_sync is the last stage.
  - Remote changes reach remote_sync after SYNC_STAGES edges.
- Flag, registered and evaluated every cycle against gray_next:
  - MODE 0: full_next = (gray_next == {~remote_sync[PTR:PTR-1], remote_sync[PTR-2:0]}).
  - MODE 1: empty_next = (gray_next == remote_sync).
- Flag timing:
  - Asserts on the same edge as the pointer step that fills or empties the FIFO; there is no one-cycle overrun window.
  - Deassertion after a remote change takes SYNC_STAGES+1 edges. This delay is pessimistic and safe.
- Simultaneous inc and remote update in one cycle: inc uses the current flag; the next flag uses gray_next and the current remote_sync.
- Wrap: the MSB toggles every 2**PTR increments; addr wraps modulo 2**PTR.
- Reset mid-operation:
  - Pointer and flag return to reset values on that edge.
  - Resetting both domains together is the system's responsibility.

Optional Feature:
Macro FIFO_PTR_LEVEL_EN.
- Defined:
  - remote_sync is converted Gray-to-binary into remote_bin.
  - level is registered: MODE 0 level = bin_next - remote_bin; MODE 1 level = remote_bin - bin_next; both modulo 2**(PTR+1).
  - level ranges 0..2**PTR and resets to 0.
- Undefined: the level port and the converter logic are absent.

Decomposition:
- Package fifo_ptr_pkg holds:
  - constants MODE_WR=0 and MODE_RD=1;
  - functions bin2gray(bin) and gray2bin(gray), parametrised by width;
  - a localparam helper for pointer width PTR+1.
- One natural sub-module: gray_sync_chain, parametrised by width and SYNC_STAGES, holding the multi-flop remote-pointer synchroniser. Its flops are reset by rst.

Test Plan (PTR=2, SYNC_STAGES=2):
1. Fill:
   - Stimulus: MODE 0, reset, remote_gray=000, inc=1 for 5 cycles.
   - Response: ptr_bin 1,2,3,4; ptr_gray 001,011,010,110; flag=1 on the 4th edge; the 5th inc is ignored and ptr_bin stays 4.
2. Drain release:
   - Stimulus: continue from 1 with remote_gray=001.
   - Response: flag holds 1 for 2 edges and clears on the 3rd; the next inc gives ptr_gray=111 and flag=1 again.
3. Empty side:
   - Stimulus: MODE 1, reset.
   - Response: flag=1 and inc is ignored. After remote_gray=001, flag=0 on the 3rd edge; one inc gives ptr_bin=1 and flag=1 on that edge.
4. Wrap:
   - Stimulus: MODE 0, remote_gray driven to track the local pointer with lag 2, 16 increments.
   - Response: ptr_bin returns to 0 twice; every ptr_gray step has Hamming distance 1, including 100 -> 000.
5. Reset mid-operation:
   - Stimulus: rst=1 together with inc=1 at ptr_bin=3.
   - Response: on that edge ptr_bin=0, ptr_gray=0, flag at its MODE reset value, and sync stages cleared.
6. Level (FIFO_PTR_LEVEL_EN):
   - Stimulus: MODE 0, 3 pushes, remote_gray=001.
   - Response: level 1,2,3, then 2 after the sync delay.
